// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_t;

  localparam int          INST_W        = 32;
  localparam logic [31:0] NOP_INST      = 32'h00000013;
  localparam logic [63:0] RESET_PC_DFLT = 64'h80000000;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: hold, advance by one instruction, or take a redirect.
module ifu_pc_reg #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  // Redirect outranks the sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= i_redirect_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, wrong-path drop, decode handshake.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DFLT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_misaligned,
  output logic [63:0]       fetch_count
);

  ifu_state_t        r_state;
  ifu_state_t        w_state_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic [XLEN-1:0]   w_pc;
  logic              w_pc_inc;
  logic              w_pc_redirect;
  logic              w_capture;
  logic              w_count_inc;
  logic [XLEN-1:0]   r_out_pc;
  logic [INST_W-1:0] r_out_inst;
  logic [63:0]       r_fetch_count;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (w_pc_inc),
    .i_redirect    (w_pc_redirect),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_drop_nxt    = r_drop;
    w_pc_inc      = 1'b0;
    w_pc_redirect = 1'b0;
    w_capture     = 1'b0;
    w_count_inc   = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_pc_redirect = redirect_valid;
        if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
          // The in-flight request was for the old pc; its response is wrong-path.
          w_drop_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        w_pc_redirect = redirect_valid;
        if (imem_resp_valid) begin
          w_drop_nxt = 1'b0;
          if (redirect_valid || r_drop) begin
            w_state_nxt = S_REQ;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_OUT;
          end
        end else if (redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_OUT: begin
        w_pc_redirect = redirect_valid;
        w_pc_inc      = out_ready;
        w_count_inc   = out_ready;
        if (out_ready || redirect_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_drop        <= 1'b0;
      r_out_pc      <= '0;
      r_out_inst    <= NOP_INST;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_capture) begin
        r_out_pc   <= w_pc;
        r_out_inst <= imem_resp_data;
      end
      if (w_count_inc) begin
        r_fetch_count <= r_fetch_count + 64'd1;
      end
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = w_pc;
  assign out_valid      = (r_state == S_OUT);
  assign out_pc         = r_out_pc;
  assign out_inst       = r_out_inst;
  assign out_misaligned = (r_out_pc[1:0] != 2'b00);
  assign fetch_count    = r_fetch_count;

  a_resp_only_when_waiting : assert property (
    @(posedge clk) disable iff (!rst_n) imem_resp_valid |-> (r_state == S_WAIT)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with hand-computed expectations.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misaligned;
  logic [63:0] fetch_count;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .XLEN     (64),
    .RESET_PC (64'h80000000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_misaligned  (out_misaligned),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request accepted, then response one cycle later; leaves the DUT in S_OUT.
  task automatic fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'h13);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_fetch_count", fetch_count, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic fetch
    chk("req_valid_after_rst", {63'd0, imem_req_valid}, 64'd1);
    chk("req_addr_after_rst", imem_req_addr, 64'h80000000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("no_req_in_wait", {63'd0, imem_req_valid}, 64'd0);
    chk("no_out_in_wait", {63'd0, out_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00100093;
    tick();
    imem_resp_valid = 1'b0;
    chk("out_valid_1", {63'd0, out_valid}, 64'd1);
    chk("out_pc_1", out_pc, 64'h80000000);
    chk("out_inst_1", {32'd0, out_inst}, 64'h00100093);
    chk("out_misaligned_1", {63'd0, out_misaligned}, 64'd0);

    // Backpressure from decode
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_out_pc", out_pc, 64'h80000000);
      chk("stall_out_inst", {32'd0, out_inst}, 64'h00100093);
      chk("stall_no_req", {63'd0, imem_req_valid}, 64'd0);
      chk("stall_pc_held", imem_req_addr, 64'h80000000);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("next_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("next_req_addr", imem_req_addr, 64'h80000004);
    chk("fetch_count_1", fetch_count, 64'd1);
    chk("out_valid_drop", {63'd0, out_valid}, 64'd0);

    // Redirect while waiting: late response is discarded
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80000100;
    tick();
    redirect_valid = 1'b0;
    chk("wait_redir_no_out", {63'd0, out_valid}, 64'd0);
    chk("wait_redir_no_req", {63'd0, imem_req_valid}, 64'd0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdeadbeef;
    tick();
    imem_resp_valid = 1'b0;
    chk("dropped_no_out", {63'd0, out_valid}, 64'd0);
    chk("redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("redir_req_addr", imem_req_addr, 64'h80000100);

    // Redirect coincident with out handshake
    fetch(32'h00000033);
    chk("out_pc_redir", out_pc, 64'h80000100);
    chk("out_inst_redir", {32'd0, out_inst}, 64'h33);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80000200;
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    chk("count_on_redir_hs", fetch_count, 64'd2);
    chk("redir_wins_addr", imem_req_addr, 64'h80000200);

    // Misaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80000002;
    tick();
    redirect_valid = 1'b0;
    chk("req_redirect_stay", {63'd0, imem_req_valid}, 64'd1);
    chk("misaligned_req_addr", imem_req_addr, 64'h80000002);
    fetch(32'h12345678);
    chk("mis_out_valid", {63'd0, out_valid}, 64'd1);
    chk("mis_flag", {63'd0, out_misaligned}, 64'd1);
    chk("mis_out_pc", out_pc, 64'h80000002);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mis_next_addr", imem_req_addr, 64'h80000006);
    chk("fetch_count_3", fetch_count, 64'd3);

    // Asynchronous reset in S_WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_fetch_count", fetch_count, 64'd0);
    chk("arst_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("arst_req_addr", imem_req_addr, 64'h80000000);
    chk("arst_out_inst", {32'd0, out_inst}, 64'h13);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_addr", imem_req_addr, 64'h80000000);

    // PC wrap and squash on redirect without handshake
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFFFFFFFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    fetch(32'h00000013);
    chk("wrap_out_pc", out_pc, 64'hFFFFFFFFFFFFFFFC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("wrap_addr", imem_req_addr, 64'd0);
    chk("wrap_count", fetch_count, 64'd1);
    fetch(32'h00000093);
    chk("zero_out_pc", out_pc, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80000040;
    tick();
    redirect_valid = 1'b0;
    chk("squash_out_valid", {63'd0, out_valid}, 64'd0);
    chk("squash_count", fetch_count, 64'd1);
    chk("squash_addr", imem_req_addr, 64'h80000040);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage and supplies its 32-bit `inst` input.
- Holds the PC and issues one fetch request at a time to instruction memory over a valid/ready request channel plus a response channel.
- Presents {pc, inst} to decode with a valid/ready handshake.
- Accepts redirects (jal/jalr/branch taken) from execute and discards wrong-path responses.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h80000000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  response data valid (always accepted, no backpressure).
- imem_resp_data  in  32  fetched instruction word.
- redirect_valid  in  1  control-flow redirect from execute.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  {out_pc, out_inst} valid to decode.
- out_ready  in  1  decode accepts instruction.
- out_pc  out  XLEN  PC of presented instruction.
- out_inst  out  32  presented instruction (feeds decode `inst`).
- out_misaligned  out  1  out_pc[1:0] != 0; qualifies out_valid.
- fetch_count  out  64  number of instructions accepted by decode.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=S_REQ, drop=0.
  - out_valid=0, out_inst=32'h00000013 (nop), out_pc=0, fetch_count=0.
  - imem_req_valid is combinational from state, so it is 1 once out of reset.
- States:
  - S_REQ: imem_req_valid=1, imem_req_addr=pc.
  - S_WAIT: one request outstanding.
  - S_OUT: out_valid=1.
- S_REQ:
  - req handshake (valid&ready) -> S_WAIT.
  - No handshake -> stay.
  - redirect without handshake: pc<=redirect_pc, stay S_REQ.
  - redirect with handshake: pc<=redirect_pc, drop<=1, -> S_WAIT.
- S_WAIT:
  - resp_valid & !drop & !redirect: out_inst<=resp_data, out_pc<=pc -> S_OUT.
  - resp_valid & drop: drop<=0 -> S_REQ (response discarded).
  - redirect & !resp_valid: pc<=redirect_pc, drop<=1, stay.
  - redirect & resp_valid: response discarded, pc<=redirect_pc, drop<=0 -> S_REQ.
- S_OUT:
  - out_valid=1; out_pc/out_inst/out_misaligned held stable until handshake.
  - out_ready & !redirect: pc<=pc+4 (mod 2^XLEN, wraps silently), fetch_count+=1 -> S_REQ.
  - redirect & !out_ready: pc<=redirect_pc -> S_REQ; instruction squashed, never handed over.
  - redirect & out_ready: handshake completes, fetch_count+=1, pc<=redirect_pc (redirect wins over pc+4) -> S_REQ.
- Latency: request accepted cycle N; response at the earliest in N+1; out_valid asserted the cycle after the response; next request the cycle after the out handshake. Best-case throughput is 1 instr per 3 cycles.
- Exactly one outstanding request; imem_req_valid is never asserted in S_WAIT or S_OUT.
- resp_valid in S_REQ or S_OUT is a protocol error: ignored, and a simulation assertion fires.
- Reset mid-operation: all state returns to reset values immediately; a response for a pre-reset request must not arrive (memory shares the reset).
- out_misaligned = out_pc[1:0]!=0. The fetch is still issued; decode/trap logic handles the flag.

Decomposition:
- Shared package holds:
  - state enum S_REQ=2'd0, S_WAIT=2'd1, S_OUT=2'd2.
  - NOP_INST=32'h00000013.
  - RESET_PC default.
  - INST_W=32.
- One sub-module, ifu_pc_reg: async-reset PC register with next-pc mux (hold / pc+4 / redirect, redirect highest priority).
- The FSM, the drop flag and the output register stay in the top module.

Test Plan:
- Reset release, req_ready=1, resp 1 cycle later with 32'h00100093, out_ready=1:
  - imem_req_addr=0x80000000 and out_pc=0x80000000.
  - next request at 0x80000004.
  - fetch_count=1.
- out_ready held 0 for 5 cycles in S_OUT:
  - out_valid, out_pc and out_inst stay constant.
  - no new imem request.
  - pc advances only after out_ready=1.
- Redirect to 0x80000100 while in S_WAIT; response 32'hdeadbeef arrives 2 cycles later:
  - response dropped, out_valid stays 0.
  - next request addr=0x80000100.
- Redirect to 0x80000200 in the same cycle as out_ready in S_OUT:
  - fetch_count increments.
  - next imem_req_addr=0x80000200, not pc+4.
- Redirect to 0x80000002, then a fetch:
  - out_valid with out_misaligned=1 and out_pc=0x80000002.
  - after the handshake, next addr=0x80000006.
- Assert rst_n=0 asynchronously mid-S_WAIT:
  - out_valid=0, fetch_count=0, state S_REQ immediately.
  - after release, imem_req_addr=0x80000000.
